// File: rtl/alu_exec_ctrl_if.sv
// Handshake bundle between ID/EX, the execute sequencer and writeback.
// Operand and result buses use MSB-first numbering (bit 0 = MSB).
interface alu_exec_ctrl_if #(
  parameter int RD_W = 5
);
  logic            in_valid;
  logic            in_ready;
  logic [5:0]      in_opcode;
  logic [1:0]      in_ww;
  logic [0:63]     in_op1;
  logic [0:63]     in_op2;
  logic [RD_W-1:0] in_rd;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [0:63]     out_data;
  logic [RD_W-1:0] out_rd;
  logic            out_err;
  logic            ex_stall;

  modport master (
    output in_valid, in_opcode, in_ww, in_op1, in_op2, in_rd, flush, out_ready,
    input  in_ready, out_valid, out_data, out_rd, out_err, ex_stall
  );

  modport slave (
    input  in_valid, in_opcode, in_ww, in_op1, in_op2, in_rd, flush, out_ready,
    output in_ready, out_valid, out_data, out_rd, out_err, ex_stall
  );
endinterface

// File: rtl/alu_exec_ctrl.sv
// Execute-stage sequencer: holds ALU inputs for the opcode latency, captures the result.
// Optional macro ALU_DIVZERO_CHK_EN enables per-lane divide-by-zero detection.
module alu_exec_ctrl #(
  parameter int MUL_LAT  = 2,
  parameter int DIV_LAT  = 8,
  parameter int SQRT_LAT = 6,
  parameter int RD_W     = 5
) (
  input  logic        clk,
  input  logic        reset_n,
  alu_exec_ctrl_if.slave bus,
  output logic [0:63] alu_op1,
  output logic [0:63] alu_op2,
  output logic [5:0]  alu_opcode,
  output logic [1:0]  alu_ww,
  input  logic [0:63] alu_result
);
  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? ((MUL_LAT > SQRT_LAT) ? MUL_LAT : SQRT_LAT)
                                               : ((DIV_LAT > SQRT_LAT) ? DIV_LAT : SQRT_LAT);
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [RD_W-1:0] rd_reg;
  logic            bad_op_reg;
  logic            out_valid_reg, out_valid_next;
  logic [0:63]     out_data_reg;
  logic [RD_W-1:0] out_rd_reg;
  logic            accept, capture;
  logic            in_ready_c, ex_stall_c;
  logic [7:0]      lane_kill;
  logic [0:63]     cap_data;

  function automatic logic [CNT_W-1:0] lat_of(input logic [5:0] op);
    case (op)
      6'd8, 6'd9, 6'd16, 6'd17: lat_of = CNT_W'(MUL_LAT);
      6'd14, 6'd15:             lat_of = CNT_W'(DIV_LAT);
      6'd18:                    lat_of = CNT_W'(SQRT_LAT);
      default:                  lat_of = '0;
    endcase
  endfunction

  // Opcodes 1..18 are implemented by the ALU; anything else yields a zero result.
  function automatic logic is_bad_op(input logic [5:0] op);
    is_bad_op = (op == 6'd0) || (op > 6'd18);
  endfunction

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    out_valid_next = out_valid_reg;
    accept         = 1'b0;
    capture        = 1'b0;
    in_ready_c     = 1'b0;
    ex_stall_c     = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready_c = 1'b1;
        if (!bus.flush && bus.in_valid) begin
          accept     = 1'b1;
          cnt_next   = lat_of(bus.in_opcode);
          state_next = BUSY;
        end
      end
      BUSY: begin
        ex_stall_c = 1'b1;
        if (bus.flush) begin
          state_next = IDLE;
        end else if (cnt_reg != '0) begin
          cnt_next = cnt_reg - CNT_W'(1);
        end else begin
          capture        = 1'b1;
          out_valid_next = 1'b1;
          state_next     = DONE;
        end
      end
      DONE: begin
        in_ready_c = bus.out_ready;
        ex_stall_c = ~bus.out_ready;
        if (bus.flush) begin
          out_valid_next = 1'b0;
          state_next     = IDLE;
        end else if (bus.out_ready) begin
          out_valid_next = 1'b0;
          if (bus.in_valid) begin
            accept     = 1'b1;
            cnt_next   = lat_of(bus.in_opcode);
            state_next = BUSY;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

`ifdef ALU_DIVZERO_CHK_EN
  logic [7:0] byte_zero;
  logic [7:0] zmask_in;
  logic [7:0] zmask_reg;
  logic       out_err_reg;
  logic       div_op_in;

  assign div_op_in = (bus.in_opcode == 6'd14) || (bus.in_opcode == 6'd15);

  // Zero detection is done per byte, then widened to the element size selected by ww.
  for (genvar gi = 0; gi < 8; gi++) begin : g_zero
    localparam int H = (gi / 2) * 2;
    localparam int W = (gi / 4) * 4;
    logic lane_zero;
    assign byte_zero[gi] = (bus.in_op2[gi*8 +: 8] == 8'h00);
    always_comb begin
      case (bus.in_ww)
        2'b00:   lane_zero = byte_zero[gi];
        2'b01:   lane_zero = &byte_zero[H +: 2];
        2'b10:   lane_zero = &byte_zero[W +: 4];
        default: lane_zero = &byte_zero;
      endcase
    end
    assign zmask_in[gi]  = div_op_in & lane_zero;
    assign lane_kill[gi] = bad_op_reg | zmask_reg[gi];
  end
  assign bus.out_err = out_err_reg;
`else
  assign lane_kill   = {8{bad_op_reg}};
  assign bus.out_err = 1'b0;
`endif

  for (genvar gi = 0; gi < 8; gi++) begin : g_cap
    assign cap_data[gi*8 +: 8] = lane_kill[gi] ? 8'h00 : alu_result[gi*8 +: 8];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      alu_op1       <= '0;
      alu_op2       <= '0;
      alu_opcode    <= '0;
      alu_ww        <= '0;
      rd_reg        <= '0;
      bad_op_reg    <= 1'b0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_rd_reg    <= '0;
`ifdef ALU_DIVZERO_CHK_EN
      zmask_reg     <= '0;
      out_err_reg   <= 1'b0;
`endif
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      out_valid_reg <= out_valid_next;
      if (accept) begin
        alu_op1    <= bus.in_op1;
        alu_op2    <= bus.in_op2;
        alu_opcode <= bus.in_opcode;
        alu_ww     <= bus.in_ww;
        rd_reg     <= bus.in_rd;
        bad_op_reg <= is_bad_op(bus.in_opcode);
`ifdef ALU_DIVZERO_CHK_EN
        zmask_reg  <= zmask_in;
`endif
      end
      if (capture) begin
        out_data_reg <= cap_data;
        out_rd_reg   <= rd_reg;
`ifdef ALU_DIVZERO_CHK_EN
        out_err_reg  <= |zmask_reg;
`endif
      end
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.ex_stall  = ex_stall_c;
  assign bus.out_valid = out_valid_reg;
  assign bus.out_data  = out_data_reg;
  assign bus.out_rd    = out_rd_reg;
endmodule
